down_counter_timer: RTL and testbench
=====================================

Name: down_counter_timer

Overview:
Loadable down-counting timer. It is the counting-down complement of the team's loadable up counter. It is loaded with a terminal value, counts to zero under start/pause/stop control, and emits a one-cycle terminal-count pulse plus a sticky done flag. It sits beside the up counter as a programmable delay/timeout source for control logic.

Parameters:
WIDTH, 4, width of count, data and the internal reload register

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
load  input  1  load data into count and reload register
data  input  WIDTH  value to load
start  input  1  begin/restart countdown
pause  input  1  hold count while running
stop  input  1  abort countdown, return to IDLE
count  output  WIDTH  current count (registered)
busy  output  1  high in RUN or HOLD
tc  output  1  terminal-count pulse, one cycle (registered)
done  output  1  sticky completion flag (registered)

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous, active-high.
- Reset values: count=0, reload_reg=0, state=IDLE, busy=0, tc=0, done=0.
- Priority per edge: rst > load > stop > start > pause > count.
- FSM states:
  - IDLE: count held.
  - RUN: decrement.
  - HOLD: paused.
  - DONE: count=0, done=1.
- load (any state): count<=data, reload_reg<=data, state->IDLE, done<=0, tc<=0. start and pause in the same cycle are ignored.
- start:
  - Honoured only in IDLE/DONE; ignored in RUN/HOLD.
  - In IDLE, count N>=1: ->RUN with count unchanged. If pause is also high: ->HOLD.
  - In IDLE, count==0: ->DONE, tc=1 next cycle, done=1.
  - In DONE: count<=reload_reg and ->RUN. If reload_reg==0: tc pulses again, stays DONE.
- RUN:
  - pause=1: ->HOLD, count unchanged.
  - Otherwise count<=count-1.
  - On count==1: count<=0, tc<=1, done<=1, ->DONE.
- HOLD:
  - pause=1: hold.
  - pause=0: behaves exactly as RUN on that edge (decrement, no bubble).
- stop: honoured in RUN/HOLD. ->IDLE, count held, done unchanged, tc=0. Ignored in IDLE/DONE.
- Latency: start sampled with count=N>=1 and pause low gives tc high in the cycle after the (N+1)th edge counted from the start edge (start edge = edge 1). count shows N, N-1 ... 0.
- tc is high for exactly one cycle per terminal event. It is 0 in all other cycles.
- Arithmetic: modulo 2^WIDTH. Underflow below 0 never occurs; decrement is gated at 0.
- done clears only on load or rst.

Optional Feature:
- Macro: DOWN_COUNTER_AUTO_RELOAD_EN.
- Defined:
  - In RUN/HOLD, reaching 0 keeps state RUN (or HOLD if pause is high).
  - The next non-paused edge loads count<=reload_reg. No tc on the reload edge.
  - Output is periodic: tc every reload_reg+1 cycles. done is set on the first tc and stays set.
  - stop is the only way out besides load/rst.
- Undefined: count stops in DONE as above; the auto-reload logic is absent.

Decomposition:
- Shared package counter_pkg holds:
  - state enum (IDLE, RUN, HOLD, DONE), 2-bit encoding;
  - default WIDTH constant shared with the up counter.
- No sub-module. FSM, reload register and decrementer fit naturally in one module.

Test Plan:
1. rst high for 2 cycles -> count=0, busy=0, tc=0, done=0. load=1 data=5, then start -> count 5,4,3,2,1,0. tc high for one cycle when count==0. done=1, busy=0.
2. data=4, start, pause high for 3 cycles after count=2 -> count stays 2 for 3 cycles, busy=1. tc arrives 3 cycles later than case 1 timing.
3. data=0, start -> next cycle tc=1, done=1, state DONE. Then start in DONE with reload_reg=0 -> tc pulses again.
4. data=6, start, stop when count=3 -> count holds 3, busy=0, no tc. Then start -> resumes from 3, tc after 4 edges.
5. Mid-run load data=9 with start and rst in separate runs:
   - load -> count=9, IDLE, done=0; the simultaneous start is ignored.
   - rst mid-run -> all outputs 0 on next edge.
6. With DOWN_COUNTER_AUTO_RELOAD_EN: data=3, start -> count 3,2,1,0,3,2,1,0..., tc every 4 cycles. stop -> IDLE with count frozen.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared definitions for the loadable up/down counter family:
// the control FSM state encoding and the default counter width.
package counter_pkg;

    // Default width shared by the up counter and the down-counting timer.
    localparam int DEFAULT_WIDTH = 4;

    // Control FSM states. The 2-bit encoding is shared by both counters.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HOLD = 2'b10,
        DONE = 2'b11
    } state_e;

    // True while a countdown is in progress (running or paused).
    function automatic logic is_active(input state_e st);
        return (st == RUN) || (st == HOLD);
    endfunction

endpackage : counter_pkg

// File: rtl/down_counter_timer.sv
// Loadable down-counting timer with start/pause/stop control.
// A load captures a terminal value into both the count and a reload register.
// When the count reaches zero the timer emits a one-cycle tc pulse and sets a
// sticky done flag.
// Optional build macro DOWN_COUNTER_AUTO_RELOAD_EN: on reaching zero the timer
// stays in RUN/HOLD. It reloads from the reload register on the next unpaused
// edge and so produces a periodic tc. Without the macro the timer parks in DONE.
module down_counter_timer
    import counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             start,
    input  logic             pause,
    input  logic             stop,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc,
    output logic             done
);

    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1'b1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             active_s;

    assign active_s = is_active(state_q);

    // Next-state logic. Priority per edge: load > stop > start > pause > count.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;
        done_d   = done_q;

        if (load) begin
            // Load wins over all control inputs; any start/pause is dropped.
            count_d  = data;
            reload_d = data;
            state_d  = IDLE;
            done_d   = 1'b0;
        end else if (stop && active_s) begin
            // Abort: freeze the count and leave done untouched.
            state_d = IDLE;
        end else if (start && !active_s) begin
            case (state_q)
                IDLE: begin
                    if (count_q == CNT_ZERO) begin
                        // Zero-length countdown completes immediately.
                        state_d = DONE;
                        tc_d    = 1'b1;
                        done_d  = 1'b1;
                    end else if (pause) begin
                        state_d = HOLD;
                    end else begin
                        state_d = RUN;
                    end
                end
                DONE: begin
                    count_d = reload_q;
                    if (reload_q == CNT_ZERO) begin
                        // Nothing to count: signal completion again.
                        state_d = DONE;
                        tc_d    = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end else if (active_s) begin
            if (pause) begin
                state_d = HOLD;
            end else begin
                // An unpaused edge in HOLD counts exactly like RUN (no bubble).
                state_d = RUN;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
                if (count_q == CNT_ZERO) begin
                    // Reload edge: restart the period, no terminal pulse.
                    count_d = reload_q;
                end else begin
                    count_d = count_q - CNT_ONE;
                    if (count_q == CNT_ONE) begin
                        tc_d   = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        tc_d = 1'b0;
                    end
                end
`else
                if (count_q <= CNT_ONE) begin
                    // Terminal edge; decrement is gated so zero never wraps.
                    count_d = CNT_ZERO;
                    tc_d    = 1'b1;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    count_d = count_q - CNT_ONE;
                end
`endif
            end
        end else begin
            // IDLE or DONE with no honoured command: hold everything.
            state_d = state_q;
        end

        busy_d = is_active(state_d);
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= CNT_ZERO;
            reload_q <= CNT_ZERO;
            tc_q     <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign count = count_q;
    assign busy  = busy_q;
    assign tc    = tc_q;
    assign done  = done_q;

endmodule : down_counter_timer

// File: tb/tb_down_counter_timer.sv
// Self-checking bench for down_counter_timer. The stimulus side drives inputs
// and pushes the reference model's prediction into a queue. A monitor pops one
// prediction after every rising edge and compares it with the DUT outputs.
// Build with DOWN_COUNTER_AUTO_RELOAD_EN defined to exercise the auto-reload
// variant; the model follows the same macro.
module tb_down_counter_timer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] data = '0;
    logic         start = 1'b0;
    logic         pause = 1'b0;
    logic         stop = 1'b0;
    logic [W-1:0] count;
    logic         busy, tc, done;

    down_counter_timer #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .data  (data),
        .start (start),
        .pause (pause),
        .stop  (stop),
        .count (count),
        .busy  (busy),
        .tc    (tc),
        .done  (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int count;
        bit busy;
        bit tc;
        bit done;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Behavioural reference model: the timer described as a few flags.
    int m_count    = 0;
    int m_reload   = 0;
    bit m_counting = 0;  // countdown in progress (running or paused)
    bit m_finished = 0;  // parked after completion
    bit m_done     = 0;
    bit m_tc       = 0;

    task automatic model_update(input bit r, input bit l, input int d,
                                input bit s, input bit p, input bit sp);
        m_tc = 0;
        if (r) begin
            m_count = 0; m_reload = 0; m_counting = 0; m_finished = 0; m_done = 0;
        end else if (l) begin
            m_count = d; m_reload = d; m_counting = 0; m_finished = 0; m_done = 0;
        end else if (sp && m_counting) begin
            m_counting = 0;
        end else if (s && !m_counting) begin
            if (m_finished) begin
                m_count = m_reload;
                if (m_reload == 0) begin
                    m_tc = 1; m_done = 1;
                end else begin
                    m_finished = 0; m_counting = 1;
                end
            end else if (m_count == 0) begin
                m_finished = 1; m_tc = 1; m_done = 1;
            end else begin
                m_counting = 1;
            end
        end else if (m_counting && !p) begin
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
            if (m_count == 0) begin
                m_count = m_reload;
            end else begin
                m_count = m_count - 1;
                if (m_count == 0) begin
                    m_tc = 1; m_done = 1;
                end
            end
`else
            if (m_count > 0) m_count = m_count - 1;
            if (m_count == 0) begin
                m_tc = 1; m_done = 1; m_counting = 0; m_finished = 1;
            end
`endif
        end
    endtask

    // Drive one cycle of inputs away from the active edge and predict its result.
    task automatic step(input bit r, input bit l, input int d,
                        input bit s, input bit p, input bit sp);
        exp_t e;
        @(negedge clk);
        rst = r; load = l; data = W'(d); start = s; pause = p; stop = sp;
        model_update(r, l, d, s, p, sp);
        e.count = m_count; e.busy = m_counting; e.tc = m_tc; e.done = m_done;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compare one prediction against the DUT after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (int'(count) !== e.count) begin
                    errors++;
                    $display("FAIL count at %0t: got %0d expected %0d", $time, count, e.count);
                end
                checks++;
                if (busy !== e.busy) begin
                    errors++;
                    $display("FAIL busy at %0t: got %0b expected %0b", $time, busy, e.busy);
                end
                checks++;
                if (tc !== e.tc) begin
                    errors++;
                    $display("FAIL tc at %0t: got %0b expected %0b", $time, tc, e.tc);
                end
                checks++;
                if (done !== e.done) begin
                    errors++;
                    $display("FAIL done at %0t: got %0b expected %0b", $time, done, e.done);
                end
            end
        end
    end

    initial begin
        // 1: reset, then a full countdown from 5.
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 5, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        idle(7);

        // 2: countdown from 4 with a 3-cycle pause once the count reaches 2.
        step(0, 1, 4, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        idle(2);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0);
        idle(4);

        // 3: zero-length countdown, then restart from DONE with reload 0.
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        idle(1);
        step(0, 0, 0, 1, 0, 0);
        idle(2);

        // 4: stop at 3, then resume and finish.
        step(0, 1, 6, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        idle(3);
        step(0, 0, 0, 0, 0, 1);
        idle(2);
        step(0, 0, 0, 1, 0, 0);
        idle(5);

        // 5: mid-run load with simultaneous start, then mid-run reset.
        step(0, 1, 9, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        idle(3);
        step(0, 1, 9, 1, 1, 0);
        idle(1);
        step(0, 0, 0, 1, 0, 0);
        idle(2);
        step(1, 0, 0, 0, 0, 0);
        idle(1);

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
        // 6: periodic operation, then stop freezes the count.
        step(0, 1, 3, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        idle(11);
        step(0, 0, 0, 0, 0, 1);
        idle(3);
`endif

        // Randomized control traffic.
        for (int i = 0; i < 3000; i++) begin
            bit r, l, s, p, sp;
            r  = ($urandom_range(0, 199) == 0);
            l  = ($urandom_range(0, 99) < 6);
            s  = ($urandom_range(0, 99) < 15);
            p  = ($urandom_range(0, 99) < 25);
            sp = ($urandom_range(0, 99) < 4);
            step(r, l, int'($urandom_range(0, 15)), s, p, sp);
        end
        step(0, 0, 0, 0, 0, 0);

        // Let the monitor drain, with a bounded wait.
        repeat (3) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d predictions left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_down_counter_timer
